read_bram: RTL and testbench

Window reader for the pixel-convolution datapath: the consumer side of `load_bram`. Once the loader signals that a full window sits in the dual-port pixel BRAM, this block reads it back two rows at a time, one row per BRAM port. It streams row-pairs to the convolution core over a valid/ready handshake and returns `pixel_ack` to free the BRAM for the next window.

---
 rtl/pxconv_pkg.sv | 25 ++
 rtl/rd_pair_fifo.sv | 61 ++++++
 rtl/read_bram.sv | 168 ++++++++++++++++
 tb/tb_read_bram.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pxconv_pkg.sv
// Shared types and constants for the pixel-convolution datapath.
// Window-reader state machine encoding, pixel word geometry and the
// byte-address helper used to locate a pixel inside the window BRAM.
package pxconv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DRAIN   = 2'd2,
    ACKWAIT = 2'd3
  } rd_state_e;

  localparam int unsigned PX_BYTES      = 4;
  localparam int unsigned RD_FIFO_DEPTH = 4;
  localparam int unsigned PX_WIDTH      = 32;

  // Byte address of pixel (row, col) in a window laid out row-major.
  function automatic logic [31:0] px_addr(input logic [31:0] base,
                                          input int unsigned cols,
                                          input logic [31:0] row,
                                          input logic [31:0] col);
    return base + PX_BYTES * (row * cols + col);
  endfunction

endpackage

// File: rtl/rd_pair_fifo.sv
// Small synchronous FIFO holding row-pairs between the BRAM read pipeline
// and the downstream handshake. Push on a full FIFO and pop on an empty
// FIFO are ignored so the pointers can never corrupt.
module rd_pair_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign wr_en_s = push_i && !full_o;
  assign rd_en_s = pop_i && !empty_o;

  // Storage, pointers and occupancy; entries are cleared on reset so the
  // head reads as zero while the FIFO is empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/read_bram.sv
// Window reader: streams a resident pixel window out of the dual-port BRAM
// two rows at a time (port A even row, port B odd row), col-fastest, and
// pulses pixel_ack once the final pair has been accepted downstream.
// Optional feature macro RD_BRAM_COORD_EN adds px_row/px_col outputs and
// carries the coordinates through the output FIFO.
module read_bram
  import pxconv_pkg::*;
#(
  parameter int unsigned WND_COLS  = 16,
  parameter int unsigned WND_ROWS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wnd_in_bram,
  output logic        bram_low_en,
  output logic [31:0] bram_low_addr,
  output logic [3:0]  bram_low_we,
  input  logic [31:0] bram_low_rdata,
  output logic        bram_hi_en,
  output logic [31:0] bram_hi_addr,
  output logic [3:0]  bram_hi_we,
  input  logic [31:0] bram_hi_rdata,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [31:0] px_low_data,
  output logic [31:0] px_hi_data,
  output logic        px_last,
`ifdef RD_BRAM_COORD_EN
  output logic [7:0]  px_row,
  output logic [7:0]  px_col,
`endif
  output logic        pixel_ack
);

`ifdef RD_BRAM_COORD_EN
  localparam int unsigned TAG_W = 17;
`else
  localparam int unsigned TAG_W = 1;
`endif
  localparam int unsigned ENT_W    = 2 * PX_WIDTH + TAG_W;
  localparam int unsigned CNT_W    = $clog2(RD_FIFO_DEPTH + 1);
  localparam logic [7:0]  LAST_RP  = 8'(WND_ROWS / 2 - 1);
  localparam logic [7:0]  LAST_COL = 8'(WND_COLS - 1);

  rd_state_e         state_q;
  logic [7:0]        rp_q;
  logic [7:0]        col_q;
  logic              rd_vld_q;
  logic [TAG_W-1:0]  tag1_q;
  logic [TAG_W-1:0]  tag2_q;
  logic [TAG_W-1:0]  tag_s;
  logic              issue_s;
  logic              at_end_s;
  logic              pop_s;
  logic              space_s;
  logic [3:0]        occ_s;
  logic [31:0]       lo_addr_s;
  logic [31:0]       hi_addr_s;
  logic [ENT_W-1:0]  fifo_wdata_s;
  logic [ENT_W-1:0]  fifo_rdata_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign bram_low_we  = 4'h0;
  assign bram_hi_we   = 4'h0;
  assign px_valid     = !fifo_empty_s;
  assign px_low_data  = fifo_rdata_s[ENT_W-1 -: 32];
  assign px_hi_data   = fifo_rdata_s[TAG_W +: 32];
  assign px_last      = fifo_rdata_s[TAG_W-1];
`ifdef RD_BRAM_COORD_EN
  assign px_row       = fifo_rdata_s[15:8];
  assign px_col       = fifo_rdata_s[7:0];
`endif
  assign fifo_wdata_s = {bram_low_rdata, bram_hi_rdata, tag2_q};

  // Issue decision: FIFO entries after this edge plus reads still in
  // flight must leave room for one more pair.
  always_comb begin
    pop_s     = px_valid && px_ready;
    occ_s     = 4'(fifo_count_s) + {3'd0, rd_vld_q} + {3'd0, bram_low_en} - {3'd0, pop_s};
    space_s   = (occ_s < 4'(RD_FIFO_DEPTH)) && !fifo_full_s;
    case (state_q)
      IDLE:    issue_s = wnd_in_bram && space_s;
      READ:    issue_s = space_s;
      default: issue_s = 1'b0;
    endcase
    at_end_s  = (rp_q == LAST_RP) && (col_q == LAST_COL);
    lo_addr_s = px_addr(BASE_ADDR, WND_COLS, {23'd0, rp_q, 1'b0}, {24'd0, col_q});
    hi_addr_s = px_addr(BASE_ADDR, WND_COLS, {23'd0, rp_q, 1'b1}, {24'd0, col_q});
`ifdef RD_BRAM_COORD_EN
    tag_s     = {at_end_s, rp_q, col_q};
`else
    tag_s     = at_end_s;
`endif
  end

  // Window sequencer: issue pointer, registered BRAM port controls, read
  // pipeline tag tracking and the one-cycle completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rp_q          <= 8'd0;
      col_q         <= 8'd0;
      bram_low_en   <= 1'b0;
      bram_hi_en    <= 1'b0;
      bram_low_addr <= 32'd0;
      bram_hi_addr  <= 32'd0;
      rd_vld_q      <= 1'b0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      pixel_ack     <= 1'b0;
    end else begin
      bram_low_en <= issue_s;
      bram_hi_en  <= issue_s;
      rd_vld_q    <= bram_low_en;
      tag2_q      <= tag1_q;
      pixel_ack   <= 1'b0;
      if (issue_s) begin
        bram_low_addr <= lo_addr_s;
        bram_hi_addr  <= hi_addr_s;
        tag1_q        <= tag_s;
        if (col_q == LAST_COL) begin
          col_q <= 8'd0;
          rp_q  <= (rp_q == LAST_RP) ? 8'd0 : rp_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
      case (state_q)
        IDLE: begin
          if (wnd_in_bram) state_q <= READ;
        end
        READ: begin
          if (issue_s && at_end_s) state_q <= DRAIN;
        end
        DRAIN: begin
          // The final pair leaving with nothing behind it ends the window.
          if (pop_s && px_last && !bram_low_en && !rd_vld_q) begin
            pixel_ack <= 1'b1;
            state_q   <= ACKWAIT;
          end
        end
        ACKWAIT: begin
          if (!wnd_in_bram) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rd_pair_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_vld_q),
    .wdata_i (fifo_wdata_s),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

endmodule

// File: tb/tb_read_bram.sv
// Bench for read_bram: a 16x16 instance exercised against a window-level
// reference model (pair k -> row-pair k/C, column k%C) plus a 2x2 instance
// for latency measurement.
`timescale 1ns/1ps
module tb_read_bram;

  localparam int C = 16;
  localparam int R = 16;
  localparam int N = C * R / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wnd, ack, len, hen, valid, ready, last;
  logic [31:0] laddr, haddr, lrd, hrd, lo, hi;
  logic [3:0]  lwe, hwe;
  logic        s_wnd, s_ack, s_len, s_hen, s_valid, s_ready, s_last;
  logic [31:0] s_laddr, s_haddr, s_lrd, s_hrd, s_lo, s_hi;
  logic [3:0]  s_lwe, s_hwe;
`ifdef RD_BRAM_COORD_EN
  logic [7:0]  prow, pcol, s_prow, s_pcol;
`endif

  read_bram #(.WND_COLS(C), .WND_ROWS(R), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst(rst), .wnd_in_bram(wnd),
    .bram_low_en(len), .bram_low_addr(laddr), .bram_low_we(lwe), .bram_low_rdata(lrd),
    .bram_hi_en(hen), .bram_hi_addr(haddr), .bram_hi_we(hwe), .bram_hi_rdata(hrd),
    .px_valid(valid), .px_ready(ready), .px_low_data(lo), .px_hi_data(hi), .px_last(last),
`ifdef RD_BRAM_COORD_EN
    .px_row(prow), .px_col(pcol),
`endif
    .pixel_ack(ack));

  read_bram #(.WND_COLS(2), .WND_ROWS(2), .BASE_ADDR(32'h0)) u_small (
    .clk(clk), .rst(rst), .wnd_in_bram(s_wnd),
    .bram_low_en(s_len), .bram_low_addr(s_laddr), .bram_low_we(s_lwe), .bram_low_rdata(s_lrd),
    .bram_hi_en(s_hen), .bram_hi_addr(s_haddr), .bram_hi_we(s_hwe), .bram_hi_rdata(s_hrd),
    .px_valid(s_valid), .px_ready(s_ready), .px_low_data(s_lo), .px_hi_data(s_hi), .px_last(s_last),
`ifdef RD_BRAM_COORD_EN
    .px_row(s_prow), .px_col(s_pcol),
`endif
    .pixel_ack(s_ack));

  // BRAM models preloaded with word = address/4, one cycle read latency.
  always @(posedge clk) begin
    if (len)   lrd   <= laddr >> 2;
    if (hen)   hrd   <= haddr >> 2;
    if (s_len) s_lrd <= s_laddr >> 2;
    if (s_hen) s_hrd <= s_haddr >> 2;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window reference: pair k sits at row-pair k/C, column k%C.
  function automatic logic [31:0] m_lo(input int k);
    return 32'((2 * (k / C)) * C + (k % C));
  endfunction
  function automatic logic [31:0] m_hi(input int k);
    return m_lo(k) + 32'(C);
  endfunction

  // Monitor state for the 16x16 instance.
  int   iss, acc, acks, cyc, last_acc_cyc;
  logic hold_v;
  logic [31:0] hold_lo, hold_hi;
  logic [31:0] cap_lo [N];
  logic [31:0] cap_hi [N];
  logic        cap_last [N];

  task automatic start_window();
    iss = 0; acc = 0; acks = 0; last_acc_cyc = -100;
  endtask

  initial begin
    cyc = 0; hold_v = 1'b0; start_window();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        hold_v = 1'b0;
      end else begin
        if (len || hen) begin
          chk("en_paired", {62'd0, len, hen}, 64'd3);
          chk("lo_addr", laddr, 64'(4 * m_lo(iss)));
          chk("hi_addr", haddr, 64'(4 * m_hi(iss)));
          iss++;
          chk("occ_plus_inflight_le4", 64'(iss - acc <= 4), 64'd1);
        end
        if (hold_v) begin
          chk("valid_held", 64'(valid), 64'd1);
          chk("lo_stable", lo, hold_lo);
          chk("hi_stable", hi, hold_hi);
        end
        if (valid && ready) begin
          chk("pair_lo", lo, m_lo(acc));
          chk("pair_hi", hi, m_hi(acc));
          chk("pair_last", 64'(last), 64'(acc == N - 1));
`ifdef RD_BRAM_COORD_EN
          chk("pair_row", prow, 64'(acc / C));
          chk("pair_col", pcol, 64'(acc % C));
`endif
          if (acc < N) begin
            cap_lo[acc] = lo; cap_hi[acc] = hi; cap_last[acc] = last;
          end
          if (last) last_acc_cyc = cyc;
          acc++;
        end
        if (ack) begin
          acks++;
          chk("ack_after_last", 64'(cyc - last_acc_cyc), 64'd1);
        end
        hold_v  = valid && !ready;
        hold_lo = lo;
        hold_hi = hi;
      end
    end
  end

  // px_ready driver: fixed level or 50 % random, changed just after each edge.
  logic rnd_mode = 1'b0;
  logic ready_fix = 1'b0;
  initial begin
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  task automatic wait_ack(input int budget, input string name);
    int t = 0;
    while (acks < 1 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(acks >= 1), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_en"}, {62'd0, len, hen}, 64'd0);
    chk({tag, "_addr"}, {laddr, haddr}, 64'd0);
    chk({tag, "_data"}, {lo, hi}, 64'd0);
    chk({tag, "_last"}, 64'(last), 64'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        last;
  } vec_t;
  vec_t vt [6];

  initial begin
    int en_t, v_t, la_t, ack_t, s_acc, s_acks;

    vt[0] = '{0,   32'd0,   32'd16,  1'b0};
    vt[1] = '{1,   32'd1,   32'd17,  1'b0};
    vt[2] = '{15,  32'd15,  32'd31,  1'b0};
    vt[3] = '{16,  32'd32,  32'd48,  1'b0};
    vt[4] = '{53,  32'd101, 32'd117, 1'b0};
    vt[5] = '{127, 32'd239, 32'd255, 1'b1};

    rst = 1'b1; wnd = 1'b0; s_wnd = 1'b0; s_ready = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk_outputs_zero("reset");
    chk("reset_we", {56'd0, lwe, hwe}, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Latency on a 2x2 window with ready held high.
    en_t = -1; v_t = -1; la_t = -1; ack_t = -1; s_acc = 0; s_acks = 0;
    @(posedge clk); #1 s_wnd = 1'b1;
    @(posedge clk); #1 s_wnd = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_len && en_t < 0) en_t = t;
      if (s_valid && v_t < 0) v_t = t;
      if (s_valid && s_ready) begin
        chk("small_lo", s_lo, 64'(s_acc));
        chk("small_hi", s_hi, 64'(s_acc + 2));
        chk("small_last", 64'(s_last), 64'(s_acc == 1));
        if (s_last) la_t = t;
        s_acc++;
      end
      if (s_ack) begin
        s_acks++;
        ack_t = t;
      end
    end
    chk("small_pairs", 64'(s_acc), 64'd2);
    chk("small_acks", 64'(s_acks), 64'd1);
    chk("small_valid_lat", 64'(v_t - en_t), 64'd2);
    chk("small_ack_lat", 64'(ack_t - la_t), 64'd1);
    chk("small_ack_within5", 64'(ack_t > en_t && ack_t - en_t <= 5), 64'd1);

    // Window 1: ready held high, table-driven spot checks afterwards.
    start_window();
    ready_fix = 1'b1;
    @(posedge clk); #1 wnd = 1'b1;
    @(posedge clk); #1 wnd = 1'b0;
    wait_ack(1000, "w1_ack_timeout");
    repeat (5) @(posedge clk);
    chk("w1_pairs", 64'(acc), 64'(N));
    chk("w1_acks", 64'(acks), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("tbl_lo", cap_lo[vt[i].idx], vt[i].lo);
      chk("tbl_hi", cap_hi[vt[i].idx], vt[i].hi);
      chk("tbl_last", 64'(cap_last[vt[i].idx]), 64'(vt[i].last));
    end

    // Window 2: random backpressure, level held high well past the ack.
    start_window();
    rnd_mode = 1'b1;
    @(posedge clk); #1 wnd = 1'b1;
    wait_ack(3000, "w2_ack_timeout");
    rnd_mode = 1'b0;
    repeat (500) @(posedge clk);
    chk("w2_pairs", 64'(acc), 64'(N));
    chk("no_retrigger", 64'(iss), 64'(N));
    chk("w2_acks", 64'(acks), 64'd1);

    // Window 3 follows only after a low-then-high level.
    #1 wnd = 1'b0;
    repeat (2) @(posedge clk);
    start_window();
    #1 wnd = 1'b1;
    wait_ack(1000, "w3_ack_timeout");
    repeat (5) @(posedge clk);
    chk("w3_pairs", 64'(acc), 64'(N));
    chk("w3_acks", 64'(acks), 64'd1);
    #1 wnd = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a window, then a clean restart from (0,0).
    start_window();
    #1 wnd = 1'b1;
    @(posedge clk); #1 wnd = 1'b0;
    for (int t = 0; t < 500 && acc < 40; t++) @(posedge clk);
    chk("mid_reached_40", 64'(acc >= 40), 64'd1);
    #3 rst = 1'b0;
    #1 chk_outputs_zero("midrst");
    @(negedge clk); rst = 1'b1;
    start_window();
    repeat (5) @(posedge clk);
    chk("no_restart_without_wnd", 64'(iss), 64'd0);
    #1 wnd = 1'b1;
    @(posedge clk); #1 wnd = 1'b0;
    wait_ack(1000, "w4_ack_timeout");
    repeat (5) @(posedge clk);
    chk("w4_pairs", 64'(acc), 64'(N));
    chk("w4_first_lo", cap_lo[0], 64'd0);
    chk("w4_first_hi", cap_hi[0], 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
